// File: rtl/tx_resp_pkg.sv
// tx_resp_pkg: shared types for the TX response scheduler.
//   tx_state_t     : serialiser FSM state (IDLE, ALU_2ND)
//   SRC_RD/SRC_ALU : source ids held in last_grant for round-robin
package tx_resp_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    ALU_2ND = 1'b1
  } tx_state_t;

  localparam logic SRC_RD  = 1'b0;
  localparam logic SRC_ALU = 1'b1;

endpackage

// File: rtl/tx_resp_if.sv
// tx_resp_if: response sources + TX FIFO write side, REF_CLK domain.
//   ALU_OUT/ALU_OUT_Valid : 2-byte ALU result and its one-cycle strobe
//   RdData/RdData_Valid   : 1-byte register read and its one-cycle strobe
//   FIFO_Full             : TX FIFO full flag
//   TX_P_Data/TX_Data_Valid : byte and write pulse toward the FIFO
// master = environment (sources + FIFO), slave = scheduler.
interface tx_resp_if #(
  parameter int DATA_WIDTH = 8
);
  logic [2*DATA_WIDTH-1:0] ALU_OUT;
  logic                    ALU_OUT_Valid;
  logic [DATA_WIDTH-1:0]   RdData;
  logic                    RdData_Valid;
  logic                    FIFO_Full;
  logic [DATA_WIDTH-1:0]   TX_P_Data;
  logic                    TX_Data_Valid;

  modport master (
    output ALU_OUT, ALU_OUT_Valid, RdData, RdData_Valid, FIFO_Full,
    input  TX_P_Data, TX_Data_Valid
  );

  modport slave (
    input  ALU_OUT, ALU_OUT_Valid, RdData, RdData_Valid, FIFO_Full,
    output TX_P_Data, TX_Data_Valid
  );
endinterface

// File: rtl/resp_hold_buf.sv
// resp_hold_buf: one-entry hold register for a single-cycle response strobe.
//   clk, rst : clock, async active-high reset
//   load     : strobe; din is captured if the entry is free
//   free     : the entry's last byte is issued on this edge
//   din/dout : data in / held data
//   pend     : entry occupied
//   drop     : strobe arrived while entry occupied and not freed (comb pulse)
module resp_hold_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             free,
  input  logic [WIDTH-1:0] din,
  output logic             pend,
  output logic [WIDTH-1:0] dout,
  output logic             drop
);

  // An entry being freed on this edge can take the new strobe.
  assign drop = load & pend & ~free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= 1'b0;
      dout <= '0;
    end else if (load && !drop) begin
      pend <= 1'b1;
      dout <= din;
    end else if (free) begin
      pend <= 1'b0;
    end
  end

endmodule

// File: rtl/tx_resp_scheduler.sv
// tx_resp_scheduler: captures read / ALU response strobes, arbitrates
// round-robin and serialises them into TX FIFO bytes (RD = 1, ALU = 2).
//   CLK, RST  : clock, async active-high reset
//   CLR_ERR   : clears OVERRUN (a same-edge drop wins)
//   bus       : tx_resp_if.slave (sources in, FIFO write side out)
//   RESP_BUSY : a buffer is occupied or an ALU frame is in flight
//   OVERRUN   : sticky, a response was dropped
module tx_resp_scheduler
  import tx_resp_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter bit ALU_MSB_FIRST = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CLR_ERR,
  tx_resp_if.slave   bus,
  output logic       RESP_BUSY,
  output logic       OVERRUN
);

  logic                    rd_pend, rd_drop, rd_free;
  logic                    alu_pend, alu_drop, alu_free;
  logic [DATA_WIDTH-1:0]   rd_q;
  logic [2*DATA_WIDTH-1:0] alu_q;
  logic [DATA_WIDTH-1:0]   alu_first, alu_second;

  tx_state_t               state, state_nx;
  logic                    last_grant, grant_nx;
  logic                    issue;
  logic [DATA_WIDTH-1:0]   byte_nx;
  logic [DATA_WIDTH-1:0]   tx_data;
  logic                    tx_vld;

  resp_hold_buf #(.WIDTH(DATA_WIDTH)) u_rd_buf (
    .clk  (CLK),
    .rst  (RST),
    .load (bus.RdData_Valid),
    .free (rd_free),
    .din  (bus.RdData),
    .pend (rd_pend),
    .dout (rd_q),
    .drop (rd_drop)
  );

  resp_hold_buf #(.WIDTH(2*DATA_WIDTH)) u_alu_buf (
    .clk  (CLK),
    .rst  (RST),
    .load (bus.ALU_OUT_Valid),
    .free (alu_free),
    .din  (bus.ALU_OUT),
    .pend (alu_pend),
    .dout (alu_q),
    .drop (alu_drop)
  );

  assign alu_first  = ALU_MSB_FIRST ? alu_q[2*DATA_WIDTH-1:DATA_WIDTH] : alu_q[DATA_WIDTH-1:0];
  assign alu_second = ALU_MSB_FIRST ? alu_q[DATA_WIDTH-1:0] : alu_q[2*DATA_WIDTH-1:DATA_WIDTH];

  // Arbitration + serialiser. The ALU buffer stays pending until its second
  // byte goes out, so an RD byte can never slip into the middle of a frame.
  always_comb begin
    state_nx = state;
    grant_nx = last_grant;
    issue    = 1'b0;
    byte_nx  = tx_data;
    rd_free  = 1'b0;
    alu_free = 1'b0;
    if (!bus.FIFO_Full) begin
      case (state)
        IDLE: begin
          if (rd_pend && (!alu_pend || last_grant == SRC_ALU)) begin
            issue    = 1'b1;
            byte_nx  = rd_q;
            rd_free  = 1'b1;
            grant_nx = SRC_RD;
          end else if (alu_pend) begin
            issue    = 1'b1;
            byte_nx  = alu_first;
            grant_nx = SRC_ALU;
            state_nx = ALU_2ND;
          end
        end
        ALU_2ND: begin
          issue    = 1'b1;
          byte_nx  = alu_second;
          alu_free = 1'b1;
          state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      last_grant <= SRC_ALU;   // RD wins the first tie
      tx_data    <= '0;
      tx_vld     <= 1'b0;
      OVERRUN    <= 1'b0;
    end else begin
      state      <= state_nx;
      last_grant <= grant_nx;
      tx_data    <= byte_nx;
      tx_vld     <= issue;
      if (rd_drop || alu_drop) OVERRUN <= 1'b1;
      else if (CLR_ERR)        OVERRUN <= 1'b0;
    end
  end

  assign bus.TX_P_Data     = tx_data;
  assign bus.TX_Data_Valid = tx_vld;
  assign RESP_BUSY         = rd_pend | alu_pend | (state != IDLE);

endmodule
